// File: rtl/fetch_if.sv
// Fetch-path hazard/redirect bundle between the pipeline datapath and the
// fetch control sequencer. The master side reports hazards and redirect
// targets; the slave side (fetch_ctrl) returns PC and pipeline-register controls.
interface fetch_if;
  logic        branch_e;
  logic [31:0] branch_tgt_e;
  logic        jump_d;
  logic [31:0] jump_tgt_d;
  logic        ld_use_d;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        pc_hold;
  logic        stall_fd;
  logic        flush_fd;
  logic        flush_de;
  logic        busy;

  modport master (
    output branch_e, branch_tgt_e, jump_d, jump_tgt_d, ld_use_d,
    input  pc_load, pc_target, pc_hold, stall_fd, flush_fd, flush_de, busy
  );

  modport slave (
    input  branch_e, branch_tgt_e, jump_d, jump_tgt_d, ld_use_d,
    output pc_load, pc_target, pc_hold, stall_fd, flush_fd, flush_de, busy
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-path control and hazard sequencer for a 5-stage pipeline.
// Arbitrates branch (EX) > jump (ID) > load-use stall (ID), drives PC load/hold
// and IF/ID, ID/EX flush/stall, inserts post-redirect fetch bubbles and keeps
// saturating debug counters. Control outputs are Mealy and act in the same cycle.
module fetch_ctrl #(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fetch_if.slave           fif,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN, HOLD} state_t;

  localparam logic [3:0] BUB_LOAD = 4'(REDIRECT_BUBBLES);
  localparam bit         HAS_HOLD = (REDIRECT_BUBBLES > 0);

  state_t      state, state_nxt;
  logic [3:0]  bub_cnt, bub_nxt;
  logic        redirect_evt, stall_evt;

  logic        pc_load, pc_hold, stall_fd, flush_fd, flush_de, busy;
  logic [31:0] pc_target;

  // State and bubble counter register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      bub_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bub_cnt <= bub_nxt;
    end
  end

  // Next-state and Mealy control outputs, arbitrated by redirect age.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt    = state;
    bub_nxt      = bub_cnt;
    pc_load      = 1'b0;
    pc_target    = '0;
    pc_hold      = 1'b0;
    stall_fd     = 1'b0;
    flush_fd     = 1'b0;
    flush_de     = 1'b0;
    busy         = 1'b0;
    redirect_evt = 1'b0;
    stall_evt    = 1'b0;

    // Controls stay quiet while reset is asserted, regardless of hazards.
    if (rst_n) begin
      unique case (state)
        RUN: begin
          if (fif.branch_e) begin
            // A taken branch is older than anything in ID, so both get flushed.
            pc_load      = 1'b1;
            pc_target    = fif.branch_tgt_e;
            flush_fd     = 1'b1;
            flush_de     = 1'b1;
            redirect_evt = 1'b1;
            if (HAS_HOLD) begin
              state_nxt = HOLD;
              bub_nxt   = BUB_LOAD;
            end
          end else if (fif.jump_d) begin
            pc_load      = 1'b1;
            pc_target    = fif.jump_tgt_d;
            flush_fd     = 1'b1;
            redirect_evt = 1'b1;
            if (HAS_HOLD) begin
              state_nxt = HOLD;
              bub_nxt   = BUB_LOAD;
            end
          end else if (fif.ld_use_d) begin
            pc_hold   = 1'b1;
            stall_fd  = 1'b1;
            flush_de  = 1'b1;
            stall_evt = 1'b1;
          end
        end

        HOLD: begin
          busy = 1'b1;
          if (fif.branch_e) begin
            // A branch during the bubble window redirects and restarts the hold.
            pc_load      = 1'b1;
            pc_target    = fif.branch_tgt_e;
            flush_fd     = 1'b1;
            flush_de     = 1'b1;
            redirect_evt = 1'b1;
            if (HAS_HOLD) begin
              bub_nxt = BUB_LOAD;
            end else begin
              state_nxt = RUN;
              bub_nxt   = '0;
            end
          end else begin
            // ID holds a bubble here, so jump and load-use requests are ignored.
            pc_hold  = 1'b1;
            flush_fd = 1'b1;
            if (bub_cnt <= 4'd1) begin
              state_nxt = RUN;
              bub_nxt   = '0;
            end else begin
              bub_nxt = bub_cnt - 4'd1;
            end
          end
        end

        default: begin
          state_nxt = RUN;
          bub_nxt   = '0;
        end
      endcase
    end
  end

  assign fif.pc_load   = pc_load;
  assign fif.pc_target = pc_target;
  assign fif.pc_hold   = pc_hold;
  assign fif.stall_fd  = stall_fd;
  assign fif.flush_fd  = flush_fd;
  assign fif.flush_de  = flush_de;
  assign fif.busy      = busy;

  // Saturating debug counters; they stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (redirect_evt && (redirect_cnt != '1)) redirect_cnt <= redirect_cnt + 1'b1;
      if (stall_evt && (stall_cnt != '1))       stall_cnt    <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl. Three instances share one stimulus:
// index 0 = REDIRECT_BUBBLES 1, index 1 = REDIRECT_BUBBLES 3, index 2 =
// REDIRECT_BUBBLES 0 with 4-bit counters. A behavioural model tracks
// remaining hold cycles and event totals per instance.
module tb_fetch_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        branch_e, jump_d, ld_use_d;
  logic [31:0] branch_tgt_e, jump_tgt_d;

  fetch_if f1 ();
  fetch_if f3 ();
  fetch_if f0 ();

  assign f1.branch_e = branch_e;  assign f1.branch_tgt_e = branch_tgt_e;
  assign f1.jump_d   = jump_d;    assign f1.jump_tgt_d   = jump_tgt_d;
  assign f1.ld_use_d = ld_use_d;
  assign f3.branch_e = branch_e;  assign f3.branch_tgt_e = branch_tgt_e;
  assign f3.jump_d   = jump_d;    assign f3.jump_tgt_d   = jump_tgt_d;
  assign f3.ld_use_d = ld_use_d;
  assign f0.branch_e = branch_e;  assign f0.branch_tgt_e = branch_tgt_e;
  assign f0.jump_d   = jump_d;    assign f0.jump_tgt_d   = jump_tgt_d;
  assign f0.ld_use_d = ld_use_d;

  logic [15:0] rc1, sc1, rc3, sc3;
  logic [3:0]  rc0, sc0;

  fetch_ctrl #(.REDIRECT_BUBBLES(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .fif(f1), .redirect_cnt(rc1), .stall_cnt(sc1));
  fetch_ctrl #(.REDIRECT_BUBBLES(3), .CNT_W(16)) u3 (
    .clk(clk), .rst_n(rst_n), .fif(f3), .redirect_cnt(rc3), .stall_cnt(sc3));
  fetch_ctrl #(.REDIRECT_BUBBLES(0), .CNT_W(4)) u0 (
    .clk(clk), .rst_n(rst_n), .fif(f0), .redirect_cnt(rc0), .stall_cnt(sc0));

  typedef struct packed {
    logic        load;
    logic [31:0] tgt;
    logic        hold;
    logic        stall;
    logic        ffd;
    logic        fde;
    logic        busy;
  } ctl_t;

  ctl_t        act [3];
  logic [15:0] act_rc [3];
  logic [15:0] act_sc [3];

  assign act[0] = '{f1.pc_load, f1.pc_target, f1.pc_hold, f1.stall_fd, f1.flush_fd, f1.flush_de, f1.busy};
  assign act[1] = '{f3.pc_load, f3.pc_target, f3.pc_hold, f3.stall_fd, f3.flush_fd, f3.flush_de, f3.busy};
  assign act[2] = '{f0.pc_load, f0.pc_target, f0.pc_hold, f0.stall_fd, f0.flush_fd, f0.flush_de, f0.busy};
  assign act_rc[0] = rc1;  assign act_sc[0] = sc1;
  assign act_rc[1] = rc3;  assign act_sc[1] = sc3;
  assign act_rc[2] = {12'b0, rc0};  assign act_sc[2] = {12'b0, sc0};

  localparam int BUBS [3] = '{1, 3, 0};
  localparam int SAT  [3] = '{65535, 65535, 15};

  int hold_left [3];
  int rc_m [3];
  int sc_m [3];
  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      hold_left[i] = 0;
      rc_m[i]      = 0;
      sc_m[i]      = 0;
    end
  endtask

  task automatic drive(bit r, bit b, logic [31:0] bt, bit j, logic [31:0] jt, bit l);
    rst_n        = r;
    branch_e     = b;
    branch_tgt_e = bt;
    jump_d       = j;
    jump_tgt_d   = jt;
    ld_use_d     = l;
    if (!r) model_reset();
  endtask

  // Expected controls: a branch always redirects; otherwise the bubble window
  // swallows ID requests; otherwise jump, then load-use.
  function automatic ctl_t expect_ctl(int i);
    ctl_t e = '0;
    if (rst_n) begin
      e.busy = (hold_left[i] > 0);
      if (branch_e) begin
        e.load = 1'b1; e.tgt = branch_tgt_e; e.ffd = 1'b1; e.fde = 1'b1;
      end else if (hold_left[i] > 0) begin
        e.hold = 1'b1; e.ffd = 1'b1;
      end else if (jump_d) begin
        e.load = 1'b1; e.tgt = jump_tgt_d; e.ffd = 1'b1;
      end else if (ld_use_d) begin
        e.hold = 1'b1; e.stall = 1'b1; e.fde = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic sample();
    ctl_t e;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      e = expect_ctl(i);
      check($sformatf("u%0d pc_load", i),   32'(act[i].load),  32'(e.load));
      check($sformatf("u%0d pc_target", i), act[i].tgt,        e.tgt);
      check($sformatf("u%0d pc_hold", i),   32'(act[i].hold),  32'(e.hold));
      check($sformatf("u%0d stall_fd", i),  32'(act[i].stall), 32'(e.stall));
      check($sformatf("u%0d flush_fd", i),  32'(act[i].ffd),   32'(e.ffd));
      check($sformatf("u%0d flush_de", i),  32'(act[i].fde),   32'(e.fde));
      check($sformatf("u%0d busy", i),      32'(act[i].busy),  32'(e.busy));
      check($sformatf("u%0d redirect_cnt", i), 32'(act_rc[i]), 32'(rc_m[i]));
      check($sformatf("u%0d stall_cnt", i),    32'(act_sc[i]), 32'(sc_m[i]));
    end
  endtask

  task automatic advance();
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        hold_left[i] = 0; rc_m[i] = 0; sc_m[i] = 0;
      end else if (branch_e) begin
        hold_left[i] = BUBS[i];
        if (rc_m[i] < SAT[i]) rc_m[i]++;
      end else if (hold_left[i] > 0) begin
        hold_left[i]--;
      end else if (jump_d) begin
        hold_left[i] = BUBS[i];
        if (rc_m[i] < SAT[i]) rc_m[i]++;
      end else if (ld_use_d) begin
        if (sc_m[i] < SAT[i]) sc_m[i]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    drive(1, 0, 0, 0, 0, 0);
    sample();
    advance();
  endtask

  task automatic do_reset();
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 32'hdead_beef, 1, 32'h1234_5678, 1);
      sample();
      advance();
    end
  endtask

  initial begin
    int b, j, l;

    // Reset, then 20 idle cycles: everything quiet, counters zero.
    do_reset();
    for (int k = 0; k < 20; k++) idle_cycle();
    check("t1 rc1", 32'(rc1), 32'd0);
    check("t1 sc1", 32'(sc1), 32'd0);

    // One-bubble jump: same-cycle redirect, one hold cycle, back to RUN.
    do_reset();
    drive(1, 0, 0, 1, 32'h40, 0);
    sample();
    check("t2 pc_load",   32'(f1.pc_load),  32'd1);
    check("t2 pc_target", f1.pc_target,     32'h40);
    check("t2 flush_fd",  32'(f1.flush_fd), 32'd1);
    check("t2 flush_de",  32'(f1.flush_de), 32'd0);
    advance();
    drive(1, 0, 0, 0, 0, 0);
    sample();
    check("t2 busy",    32'(f1.busy),    32'd1);
    check("t2 pc_hold", 32'(f1.pc_hold), 32'd1);
    advance();
    drive(1, 0, 0, 0, 0, 0);
    sample();
    check("t2 run busy", 32'(f1.busy), 32'd0);
    check("t2 rc1",      32'(rc1),     32'd1);
    advance();

    // Branch and jump together: the branch wins.
    do_reset();
    drive(1, 1, 32'h80, 1, 32'h40, 0);
    sample();
    check("t3 pc_target", f1.pc_target,     32'h80);
    check("t3 flush_fd",  32'(f1.flush_fd), 32'd1);
    check("t3 flush_de",  32'(f1.flush_de), 32'd1);
    advance();
    idle_cycle();
    drive(1, 0, 0, 0, 0, 0);
    sample();
    check("t3 rc1", 32'(rc1), 32'd1);
    advance();

    // Three load-use cycles: one stall each, no redirect.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 0, 0, 1);
      sample();
      check("t4 pc_load",  32'(f1.pc_load),  32'd0);
      check("t4 pc_hold",  32'(f1.pc_hold),  32'd1);
      check("t4 stall_fd", 32'(f1.stall_fd), 32'd1);
      check("t4 flush_de", 32'(f1.flush_de), 32'd1);
      advance();
    end
    drive(1, 0, 0, 0, 0, 0);
    sample();
    check("t4 sc1",  32'(sc1),     32'd3);
    check("t4 busy", 32'(f1.busy), 32'd0);
    advance();

    // Three-bubble instance: branch on the 2nd hold cycle restarts the hold.
    do_reset();
    drive(1, 0, 0, 1, 32'h100, 0);
    sample();
    advance();
    idle_cycle();
    drive(1, 1, 32'h200, 0, 0, 0);
    sample();
    check("t5 pc_load", 32'(f3.pc_load), 32'd1);
    check("t5 pc_hold", 32'(f3.pc_hold), 32'd0);
    check("t5 busy",    32'(f3.busy),    32'd1);
    advance();
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 0, 0, 0);
      sample();
      check("t5 rehold busy", 32'(f3.busy), 32'd1);
      advance();
    end
    drive(1, 0, 0, 0, 0, 0);
    sample();
    check("t5 end busy", 32'(f3.busy), 32'd0);
    check("t5 rc3",      32'(rc3),     32'd2);
    advance();

    // Reset during HOLD clears busy immediately; no hold after release.
    drive(1, 0, 0, 1, 32'h300, 0);
    sample();
    advance();
    drive(0, 0, 0, 0, 0, 0);
    sample();
    check("t5 rst busy", 32'(f3.busy), 32'd0);
    advance();
    drive(1, 0, 0, 0, 0, 0);
    sample();
    check("t5 post busy", 32'(f3.busy),    32'd0);
    check("t5 post hold", 32'(f3.pc_hold), 32'd0);
    advance();

    // 20 back-to-back jumps saturate the 4-bit counter of the zero-bubble instance.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(1, 0, 0, 1, 32'h40 + 32'(k * 4), 0);
      sample();
      advance();
    end
    drive(1, 0, 0, 0, 0, 0);
    sample();
    check("t6 rc0 sat", 32'(rc0), 32'hF);
    advance();

    // Randomized hazards against the model, with occasional resets.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      b = ($urandom_range(0, 99) < 15) ? 1 : 0;
      j = ($urandom_range(0, 99) < 30) ? 1 : 0;
      l = ($urandom_range(0, 99) < 35) ? 1 : 0;
      drive(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
            b[0], $urandom(), j[0], $urandom(), l[0]);
      sample();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
